pll_reconfig_seq: RTL and testbench

Sequencer for the fractional video/system PLL and its Avalon-MM reconfiguration port. At power-up it resets the PLL, waits for stable lock and then releases the core's system reset. On request it rewrites the PLL's fractional M (K) value to one of two timing profiles (native and alternate refresh), waits for relock, and re-releases system reset. It sits between the top level and the PLL/reconfig pair, on the 50 MHz reference clock domain.

---
 rtl/pll_reconfig_seq.sv | 187 ++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// PLL power-up / reconfiguration sequencer: resets the PLL, waits for stable lock, releases sys_rst,
// and rewrites the fractional K word over Avalon-MM on request. Optional lock timeout: PLL_SEQ_TIMEOUT_EN.
module pll_reconfig_seq #(
  parameter logic [31:0] K0          = 32'h2E8BA2E9,
  parameter logic [31:0] K1          = 32'h8F5C28F6,
  parameter int          PLL_RST_CYC = 16,
  parameter int          LOCK_STABLE = 1024
`ifdef PLL_SEQ_TIMEOUT_EN
  , parameter int        LOCK_TIMEOUT = 2000000,
  parameter int          MAX_RETRY    = 3
`endif
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        mode,
  input  logic        cfg_req,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        sys_rst,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_PRST, S_WLOCK, S_RUN, S_W_MODE, S_W_K, S_W_START, S_ERR
  } state_t;

  localparam int CMAX = (LOCK_STABLE > PLL_RST_CYC) ? LOCK_STABLE : PLL_RST_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_s1_q, lock_s2_q;
  logic          pend_q, pend_d;
  logic          prof_q, prof_d;
  logic          done_q, done_d;

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] retry_q, retry_d;
`endif

  // A PLL held in reset has no meaningful lock, so the synchronizer is flushed during PRST;
  // this also makes the release latency include the two synchronizer stages.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else if (state_q == S_PRST) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= S_PRST;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      prof_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      prof_q  <= prof_d;
      done_q  <= done_d;
`ifdef PLL_SEQ_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
`endif
    end
  end

  // Avalon write: mgmt_write plus address/data form the "valid" side and stay constant while
  // mgmt_waitrequest is high; the first edge with mgmt_waitrequest low accepts the word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | cfg_req;
    prof_d  = prof_q;
    done_d  = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
    tcnt_d  = '0;
    retry_d = retry_q;
`endif
    unique case (state_q)
      S_PRST: begin
        if (cnt_q == CW'(PLL_RST_CYC - 1)) begin
          state_d = S_WLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WLOCK: begin
        if (lock_s2_q) begin
          if (cnt_q == CW'(LOCK_STABLE - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            done_d  = 1'b1;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        if (state_d == S_WLOCK) begin
          if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
            cnt_d   = '0;
            retry_d = retry_q + 1'b1;
            state_d = (retry_q == RW'(MAX_RETRY - 1)) ? S_ERR : S_PRST;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`endif
      end
      S_RUN: begin
        // Lock loss outranks a pending request; the request stays pending.
        if (!lock_s2_q) begin
          state_d = S_WLOCK;
        end else if (pend_q) begin
          state_d = S_W_MODE;
          prof_d  = mode;
          pend_d  = 1'b0;
        end
      end
      S_W_MODE:  if (!mgmt_waitrequest) state_d = S_W_K;
      S_W_K:     if (!mgmt_waitrequest) state_d = S_W_START;
      S_W_START: if (!mgmt_waitrequest) state_d = S_WLOCK;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_PRST;
    endcase
  end

  always_comb begin
    pll_rst        = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    unique case (state_q)
      S_PRST, S_ERR: pll_rst = 1'b1;
      S_W_MODE:      mgmt_write = 1'b1;
      S_W_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = prof_q ? K1 : K0;
      end
      S_W_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
      end
      default: ;
    endcase
  end

  assign sys_rst     = (state_q != S_RUN);
  assign busy        = (state_q != S_RUN);
  assign cfg_done    = done_q;
  assign dbg_state_o = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  assign cfg_err     = (state_q == S_ERR);
`else
  assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: phase/queue reference model compared every cycle, plus
// hand-computed latency and write-sequence expectations. Timeout scenario under PLL_SEQ_TIMEOUT_EN.
module tb_pll_reconfig_seq;
  localparam logic [31:0] K0 = 32'h2E8BA2E9;
  localparam logic [31:0] K1 = 32'h8F5C28F6;
  localparam int PLL_RST_CYC = 16;
  localparam int LOCK_STABLE = 8;
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRY    = 3;
`endif
  localparam int PH_PRST = 0, PH_LOCK = 1, PH_RUN = 2, PH_WR = 3, PH_ERR = 4;

  logic        refclk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        cfg_req = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_rst, mgmt_write, sys_rst, busy, cfg_done, cfg_err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [2:0]  dbg_state;

  // clock / reset
  always #10 refclk = ~refclk;

  pll_reconfig_seq #(
    .K0(K0), .K1(K1), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_STABLE(LOCK_STABLE)
`ifdef PLL_SEQ_TIMEOUT_EN
    , .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
`endif
  ) dut (
    .refclk(refclk), .rst(rst), .mode(mode), .cfg_req(cfg_req), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
    .sys_rst(sys_rst), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: phases, countdowns and an expected-write queue {addr, data}
  int ph, prst_left, good_run, wait_cyc;
`ifdef PLL_SEQ_TIMEOUT_EN
  int tries;
`endif
  bit s1, s2, pend, done_m;
  logic [37:0] exp_q[$];

  function automatic void model_reset();
    ph = PH_PRST; prst_left = PLL_RST_CYC; good_run = 0; wait_cyc = 0;
`ifdef PLL_SEQ_TIMEOUT_EN
    tries = 0;
`endif
    s1 = 1'b0; s2 = 1'b0; pend = 1'b0; done_m = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void enter_lock();
    ph = PH_LOCK; good_run = 0; wait_cyc = 0;
  endfunction

  function automatic void model_step();
    bit n_s1, n_s2, n_pend;
    n_s1   = (ph == PH_PRST) ? 1'b0 : pll_locked;
    n_s2   = (ph == PH_PRST) ? 1'b0 : s1;
    n_pend = pend | cfg_req;
    done_m = 1'b0;
    case (ph)
      PH_PRST: if (prst_left == 1) enter_lock(); else prst_left--;
      PH_LOCK: begin
        if (s2) begin
          good_run++;
          if (good_run == LOCK_STABLE) begin
            ph = PH_RUN; done_m = 1'b1;
`ifdef PLL_SEQ_TIMEOUT_EN
            tries = 0;
`endif
          end
        end else good_run = 0;
`ifdef PLL_SEQ_TIMEOUT_EN
        if (ph == PH_LOCK) begin
          wait_cyc++;
          if (wait_cyc == LOCK_TIMEOUT) begin
            tries++;
            if (tries == MAX_RETRY) ph = PH_ERR;
            else begin ph = PH_PRST; prst_left = PLL_RST_CYC; end
          end
        end
`endif
      end
      PH_RUN: begin
        if (!s2) enter_lock();
        else if (pend) begin
          ph = PH_WR; n_pend = 1'b0;
          exp_q.push_back({6'd0, 32'd0});
          exp_q.push_back({6'd7, mode ? K1 : K0});
          exp_q.push_back({6'd2, 32'd0});
        end
      end
      PH_WR: begin
        if (!mgmt_waitrequest) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) enter_lock();
        end
      end
      default: ;
    endcase
    s1 = n_s1; s2 = n_s2; pend = n_pend;
  endfunction

  // scoreboard: completed-write log from the bus
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_hold[$];
  int          hold = 0;

  initial begin
    wait (cmp_en);
    forever begin
      @(negedge refclk);
      if (rst) model_reset();
      check("pll_rst", pll_rst, (ph == PH_PRST || ph == PH_ERR));
      check("sys_rst", sys_rst, (ph != PH_RUN));
      check("busy", busy, (ph != PH_RUN));
      check("cfg_done", cfg_done, done_m);
      check("cfg_err", cfg_err, (ph == PH_ERR));
      check("mgmt_write", mgmt_write, (ph == PH_WR));
      check("mgmt_address", mgmt_address, (ph == PH_WR) ? exp_q[0][37:32] : 6'd0);
      check("mgmt_writedata", mgmt_writedata, (ph == PH_WR) ? exp_q[0][31:0] : 32'd0);
      if (!rst) model_step();
      if (rst) hold = 0;
      else if (mgmt_write) begin
        hold++;
        if (!mgmt_waitrequest) begin
          log_addr.push_back(mgmt_address);
          log_data.push_back(mgmt_writedata);
          log_hold.push_back(hold);
          hold = 0;
        end
      end
    end
  end

  // Avalon slave: stalls each write for wr_stall cycles (negative = random 0..3)
  int wr_stall = 3;
  int stall_cnt = 0;
  int stall_tgt = 3;
  initial forever begin
    @(posedge refclk); #1;
    if (mgmt_write) begin
      if (stall_cnt < stall_tgt) begin
        mgmt_waitrequest = 1'b1; stall_cnt++;
      end else begin
        mgmt_waitrequest = 1'b0; stall_cnt = 0;
        stall_tgt = (wr_stall < 0) ? int'($urandom_range(0, 3)) : wr_stall;
      end
    end else begin
      mgmt_waitrequest = 1'($urandom_range(0, 1));
      stall_cnt = 0;
      stall_tgt = (wr_stall < 0) ? int'($urandom_range(0, 3)) : wr_stall;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge refclk); #1; end
  endtask

  task automatic reset_dut();
    rst = 1'b1; tick(1); rst = 1'b0;
    log_addr.delete(); log_data.delete(); log_hold.delete();
  endtask

  task automatic pulse_req(input logic m);
    mode = m; cfg_req = 1'b1; tick(1); cfg_req = 1'b0;
  endtask

  task automatic wait_sys(input logic v, input int budget, input string nm);
    int n = 0;
    while (sys_rst !== v && n < budget) begin tick(1); n++; end
    check(nm, (sys_rst === v), 1'b1);
  endtask

  initial begin
    int n, prst_n;
    logic prev;
    int low_left;
    #1 rst = 1'b1;
    pll_locked = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("rst_pll_rst", pll_rst, 1'b1);
    check("rst_sys_rst", sys_rst, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_write", mgmt_write, 1'b0);
    check("rst_addr", mgmt_address, 6'd0);
    check("rst_data", mgmt_writedata, 32'd0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    tick(2);
    rst = 1'b0;

    // power-up: pll_rst for 16 cycles, then 2 sync + 8 stable cycles to release
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick(1); n++; end
    check("pwr_pll_rst_cycles", n, PLL_RST_CYC);
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin tick(1); n++; end
    check("pwr_release_cycles", n, 2 + LOCK_STABLE);
    check("pwr_cfg_done_at_release", cfg_done, 1'b1);
    tick(1);
    check("pwr_cfg_done_one_cycle", cfg_done, 1'b0);

    // reconfigure to profile 1 with 3 stall cycles per write
    tick(2);
    log_addr.delete(); log_data.delete(); log_hold.delete();
    wr_stall = 3;
    pulse_req(1'b1);
    n = 0;
    while (mgmt_write !== 1'b1 && n < 20) begin tick(1); n++; end
    check("reconf_sys_rst_at_wmode", sys_rst, 1'b1);
    wait_sys(1'b0, 200, "reconf_relock_timeout");
    check("reconf_write_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("reconf_w0_addr", log_addr[0], 6'd0);
      check("reconf_w0_data", log_data[0], 32'd0);
      check("reconf_w1_addr", log_addr[1], 6'd7);
      check("reconf_w1_data", log_data[1], 32'h8F5C28F6);
      check("reconf_w2_addr", log_addr[2], 6'd2);
      check("reconf_w2_data", log_data[2], 32'd0);
      for (int i = 0; i < 3; i++) check("reconf_hold_cycles", log_hold[i], 4);
    end

    // lock loss in RUN: sys_rst within 3 cycles, no writes
    tick(3);
    log_addr.delete(); log_data.delete(); log_hold.delete();
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst === 1'b0 && n < 20) begin tick(1); n++; end
    check("loss_rise_within_3", (n <= 3), 1'b1);
    tick(20);
    check("loss_no_writes", log_addr.size(), 0);
    pll_locked = 1'b1;
    wait_sys(1'b0, 100, "loss_relock_timeout");

    // one-cycle lock glitch at stability count 5 restarts the count
    reset_dut();
    tick(21);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin tick(1); n++; end
    check("glitch_release_after_return", n, 2 + LOCK_STABLE);

    // two requests while in WLOCK merge into one reconfiguration
    reset_dut();
    tick(20);
    pulse_req(1'b0);
    tick(1);
    pulse_req(1'b0);
    wait_sys(1'b0, 50, "busyreq_first_run");
    wait_sys(1'b1, 20, "busyreq_reconf_start");
    wait_sys(1'b0, 300, "busyreq_relock");
    tick(30);
    check("busyreq_write_count", log_addr.size(), 3);
    if (log_addr.size() >= 2) begin
      check("busyreq_w1_addr", log_addr[1], 6'd7);
      check("busyreq_w1_data", log_data[1], 32'h2E8BA2E9);
    end

    // reset in the middle of a stalled write drops mgmt_write at once
    pulse_req(1'b1);
    n = 0;
    while (mgmt_write !== 1'b1 && n < 20) begin tick(1); n++; end
    tick(1);
    rst = 1'b1;
    #1;
    check("rst_midwrite_drop", mgmt_write, 1'b0);
    tick(1);
    rst = 1'b0;
    wait_sys(1'b0, 100, "rst_midwrite_release");

`ifdef PLL_SEQ_TIMEOUT_EN
    // lock never arrives: three PRST/WLOCK rounds, then sticky error
    pll_locked = 1'b0;
    reset_dut();
    n = 0; prst_n = 1; prev = pll_rst;
    while (cfg_err !== 1'b1 && n < 2000) begin
      tick(1); n++;
      if (pll_rst && !prev && !cfg_err) prst_n++;
      prev = pll_rst;
    end
    check("tmo_err_cycle", n, 3 * (PLL_RST_CYC + LOCK_TIMEOUT));
    check("tmo_prst_rounds", prst_n, 3);
    pll_locked = 1'b1;
    tick(50);
    check("tmo_err_sticky", cfg_err, 1'b1);
    check("tmo_err_pll_rst", pll_rst, 1'b1);
    check("tmo_err_busy", busy, 1'b1);
    reset_dut();
    wait_sys(1'b0, 100, "tmo_recover");
`endif

    // randomized traffic: requests, lock drops, random stalls, occasional reset
    wr_stall = -1;
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_req = ($urandom_range(0, 99) < 5);
      mode    = 1'($urandom_range(0, 1));
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        pll_locked = 1'b0;
        low_left = $urandom_range(1, 15);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    cfg_req = 1'b0; rst = 1'b0; pll_locked = 1'b1;
    tick(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
